aes_block_packer: RTL
=====================

# aes_block_packer

Input staging block directly upstream of the AES-128 encrypt datapath. It accepts a plaintext stream of W-bit words under a valid/ready handshake and packs them into 128-bit blocks. A partial final block is zero-padded. Each block is presented on a registered valid/ready output that drives the encryptor's 128-bit `in` bus. One block of buffering lets packing of block n+1 overlap a stalled block n.

## Interface
- `W`, default 32, word width in bits; legal values are 8, 16, 32 and 64.
- `K` (localparam, = 128/W), words per block.
- `CW` (localparam, = $clog2(K+1)), width of word counts.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_data` input W: plaintext word.
- `in_valid` input 1: `in_data`/`in_last` valid.
- `in_last` input 1: the word is the final word of the message.
- `in_ready` output 1: the packer accepts a word this cycle.
- `out_block` output 128: packed block, first word in bits [127:128-W].
- `out_valid` output 1: `out_block` holds a complete block.
- `out_ready` input 1: downstream takes the block this cycle.
- `out_last` output 1: the block contains the message's final word.
- `out_nwords` output CW: number of real (non-pad) words in the block, range 1..K.

## Operation
- A word transfers when `in_valid && in_ready`. A block transfers when `out_valid && out_ready`.
- Assembly register `asm`(128), word counter `cnt` (0..K-1) and flag `asm_last`.
- Word i of a block (0-based) is written to bits [127-i*W -: W]; unwritten positions read as 0.
- Block completes when the word accepted has `cnt==K-1` or `in_last==1`. On completion, nwords = `cnt+1`.
- FSM with two states:
  - **FILL:** `in_ready=1`.
    - On completion, if the output register is free, or is being drained this same cycle, the completed block (including the current word) loads the output register. Then `asm` clears to 0, `cnt` goes to 0, and the FSM stays in FILL.
    - On completion with the output register occupied and not draining, the current word is written into `asm` and the FSM goes to HOLD. `nwords`/`last` are latched.
  - **HOLD:** `in_ready=0`.
    - When the output register drains, `asm` moves into it on that same edge. `asm` then clears, `cnt` goes to 0, and the FSM returns to FILL.
- The output register loads `out_block`, `out_last` and `out_nwords` together. `out_valid` stays set until the block transfers.
- Output fields are stable while `out_valid && !out_ready`.
- `in_last` on word 0 gives a block with nwords=1 and 96 zero bits when W=32.
- `in_last` asserted on the Kth word gives a full block with `out_last=1` and no extra pad block.
- `in_data` is ignored when `in_valid=0`. `out_ready` is ignored when `out_valid=0`.

## Timing
- Reset values, all asynchronous:
  - FSM=FILL, `cnt`=0, `asm`=0.
  - `out_valid`=0, `out_block`=0, `out_last`=0, `out_nwords`=0.
  - `in_ready`=0 while `rst` is high and 1 in the first cycle after release.
- Latency: `out_valid` rises on the edge that accepts the completing word.
- Throughput: one word per cycle sustained when `out_ready=1`. No bubble between blocks.
- `in_ready` is a combinational function of state only (`state==FILL`). It does not depend on `in_valid`.
- `out_ready` low stalls the output. Packing continues until the next block completes, then HOLD backpressures the input.
- Simultaneous drain and completion in FILL: the new block replaces the drained one on the same edge, so `out_valid` stays 1.
- Reset mid-message discards `asm`, the output block and partial counts.

## Structure
- Shared package `aes_pkg`: `AES_BLOCK_W=128` and the `aes_block_t` typedef (logic [127:0]), both reused by the encryptor-side wrappers.
- No sub-module is required. The output register is inline.
- Estimated at roughly 150 lines of RTL.

## Test plan
1. **Back-to-back full blocks.** W=32, `out_ready=1`, 8 words with `in_last` on word 8: 00112233, 44556677, 8899aabb, ccddeeff, then 00010203 .. 0c0d0e0f.
   - Blocks `00112233445566778899aabbccddeeff` (last=0, nwords=4) and `000102030405060708090a0b0c0d0e0f` (last=1, nwords=4).
   - `in_ready` stays 1 throughout.
2. **Partial final block.** 2 words deadbeef, cafef00d, `in_last` on the second.
   - `out_block=deadbeefcafef00d0000000000000000`, nwords=2, last=1.
3. **Single-word message.** `in_last` on the first word 01020304.
   - `out_block=01020304` followed by 24 zero hex digits, nwords=1.
4. **Stall and recovery.** `out_ready=0`, stream 12 words.
   - Block 1 is held stable.
   - Block 2 fills `asm`, the FSM enters HOLD and `in_ready` goes to 0 after the 8th word. The 9th word is not accepted.
   - After `out_ready` is raised for 1 cycle, block 2 appears on the next cycle, `in_ready` returns to 1 and the remaining words are accepted.
5. **Reset mid-block.** Assert `rst` after 2 words, then release.
   - All outputs return to their reset values.
   - A new 4-word message produces a block containing only the new words.
6. **Parameter sweep.** W=8, 16 bytes 00..0f with `in_last` on the final byte.
   - `out_block=000102030405060708090a0b0c0d0e0f`, nwords=16.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : aes_pkg
//  Purpose  : Shared AES block width and block type, used by the packer and
//             by the encryptor-side wrappers.
//  Revision : 1.0  initial release
// ============================================================================
package aes_pkg;

    localparam int AES_BLOCK_W = 128;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;

endpackage
`default_nettype wire

// File: rtl/aes_block_packer.sv
`default_nettype none
// ============================================================================
//  Module   : aes_block_packer
//  Purpose  : Packs a valid/ready stream of W-bit plaintext words into
//             128-bit blocks (first word in the MSBs, short final block
//             zero-padded). It holds one block in the output register and
//             assembles the next one in parallel.
//  Revision : 1.0  initial release
// ============================================================================
module aes_block_packer
    import aes_pkg::*;
#(
    parameter  int W  = 32,
    localparam int K  = AES_BLOCK_W / W,
    localparam int CW = $clog2(K + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [W-1:0]           in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [AES_BLOCK_W-1:0] out_block,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic [CW-1:0]          out_nwords
);

    // FILL accepts words; HOLD waits for the output register to drain.
    localparam logic [0:0] c_ST_FILL = 1'b0;
    localparam logic [0:0] c_ST_HOLD = 1'b1;

    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;

    aes_block_t             r_asm;
    aes_block_t             w_asm_nxt;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_nxt;
    logic                   r_asm_last;
    logic                   w_asm_last_nxt;
    logic [CW-1:0]          r_asm_nwords;
    logic [CW-1:0]          w_asm_nwords_nxt;

    aes_block_t             r_out_block;
    aes_block_t             w_out_block_nxt;
    logic                   r_out_valid;
    logic                   w_out_valid_nxt;
    logic                   r_out_last;
    logic                   w_out_last_nxt;
    logic [CW-1:0]          r_out_nwords;
    logic [CW-1:0]          w_out_nwords_nxt;

    aes_block_t             w_merged;
    logic                   w_in_fire;
    logic                   w_drain;
    logic                   w_out_free;
    logic                   w_complete;
    logic [CW-1:0]          w_cnt_inc;

    // Ready is a pure function of state, forced low while reset is held.
    assign in_ready   = (r_state == c_ST_FILL) && !rst;

    assign out_block  = r_out_block;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    assign out_nwords = r_out_nwords;

    assign w_in_fire  = in_valid && in_ready;
    assign w_drain    = r_out_valid && out_ready;
    assign w_out_free = !r_out_valid || out_ready;
    assign w_complete = w_in_fire && ((r_cnt == CW'(K - 1)) || in_last);
    assign w_cnt_inc  = r_cnt + CW'(1);

    // Assembly register with the incoming word dropped into lane r_cnt.
    genvar gi;
    for (gi = 0; gi < K; gi++) begin : g_lane
        assign w_merged[AES_BLOCK_W-1-gi*W -: W] =
            (r_cnt == CW'(gi)) ? in_data : r_asm[AES_BLOCK_W-1-gi*W -: W];
    end

    // Next-state and datapath decode for the FILL/HOLD machine.
    always_comb begin
        w_state_nxt      = r_state;
        w_asm_nxt        = r_asm;
        w_cnt_nxt        = r_cnt;
        w_asm_last_nxt   = r_asm_last;
        w_asm_nwords_nxt = r_asm_nwords;
        w_out_block_nxt  = r_out_block;
        w_out_valid_nxt  = r_out_valid;
        w_out_last_nxt   = r_out_last;
        w_out_nwords_nxt = r_out_nwords;

        // A drained block empties the output unless something reloads it below.
        if (w_drain) begin
            w_out_valid_nxt = 1'b0;
        end

        case (r_state)
            c_ST_FILL: begin
                if (w_complete && w_out_free) begin
                    // Completed block goes straight to the output register.
                    w_out_block_nxt  = w_merged;
                    w_out_valid_nxt  = 1'b1;
                    w_out_last_nxt   = in_last;
                    w_out_nwords_nxt = w_cnt_inc;
                    w_asm_nxt        = '0;
                    w_cnt_nxt        = '0;
                end else if (w_complete) begin
                    // Output still occupied: park the block and stop input.
                    w_asm_nxt        = w_merged;
                    w_asm_last_nxt   = in_last;
                    w_asm_nwords_nxt = w_cnt_inc;
                    w_state_nxt      = c_ST_HOLD;
                end else if (w_in_fire) begin
                    w_asm_nxt        = w_merged;
                    w_cnt_nxt        = w_cnt_inc;
                end
            end
            c_ST_HOLD: begin
                if (w_drain) begin
                    w_out_block_nxt  = r_asm;
                    w_out_valid_nxt  = 1'b1;
                    w_out_last_nxt   = r_asm_last;
                    w_out_nwords_nxt = r_asm_nwords;
                    w_asm_nxt        = '0;
                    w_cnt_nxt        = '0;
                    w_asm_last_nxt   = 1'b0;
                    w_state_nxt      = c_ST_FILL;
                end
            end
            default: begin
                w_state_nxt = c_ST_FILL;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Assembly and output registers; reset discards any partial message.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_asm        <= '0;
            r_cnt        <= '0;
            r_asm_last   <= 1'b0;
            r_asm_nwords <= '0;
            r_out_block  <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_nwords <= '0;
        end else begin
            r_asm        <= w_asm_nxt;
            r_cnt        <= w_cnt_nxt;
            r_asm_last   <= w_asm_last_nxt;
            r_asm_nwords <= w_asm_nwords_nxt;
            r_out_block  <= w_out_block_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_out_last   <= w_out_last_nxt;
            r_out_nwords <= w_out_nwords_nxt;
        end
    end

endmodule
`default_nettype wire
